mac_chain_drain: RTL and testbench
==================================

Name: mac_chain_drain

Overview:
- Downstream stage of the MAC chain. Captures the packed accumulator vector the chain produces (size lanes of acc_width bits) in one cycle.
- Post-processes each lane: arithmetic right shift, optional ReLU, then saturation to out_width.
- Streams the results out one lane per cycle over a valid/ready handshake to the activation buffer.
- Frees the chain to begin its next accumulation as soon as the capture is taken.

Parameters:
- size, 4, number of accumulator lanes in the packed input (matches the MAC chain length)
- acc_width, 32, bit width of each signed accumulator lane
- out_width, 8, bit width of each signed output element
- idx_width, 2, width of out_idx; must satisfy 2^idx_width >= size, minimum 1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- capture  input  1  request to latch acc_in; accepted only when busy=0
- acc_in  input  size*acc_width  packed signed accumulators; lane i = acc_in[i*acc_width +: acc_width]
- shift_amt  input  6  right-shift amount, latched with capture
- relu_en  input  1  ReLU enable, latched with capture
- busy  output  1  high from the accepted capture until the final transfer completes
- out_valid  output  1  out_data holds a valid element
- out_ready  input  1  consumer accepts the element this cycle
- out_data  output  out_width  processed signed element
- out_idx  output  idx_width  lane index of out_data
- out_last  output  1  out_data is lane size-1
- sat_flag  output  1  sticky: some lane of the current batch saturated; cleared on accepted capture

Behaviour:
- Reset and clocking:
  - Single clock domain; reset sampled on the clk edge only.
  - rst_n=0 forces state IDLE and drives busy, out_valid, out_data, out_idx, out_last and sat_flag to 0.
  - rst_n=0 overrides capture in the same cycle.
  - Reset mid-drain abandons the batch; remaining lanes are never emitted.
- FSM states: IDLE, DRAIN.
  - IDLE, capture=1: latch all lanes, shift_amt and relu_en into internal registers; clear sat_flag; go to DRAIN.
  - IDLE, capture=0: remain in IDLE.
  - DRAIN: present lanes in order 0..size-1. Go to IDLE on the transfer (out_valid && out_ready) where out_last=1.
- Capture timing:
  - busy=1 in DRAIN, 0 in IDLE.
  - capture while busy=1 is ignored, including the cycle of the final transfer.
  - The earliest new capture is the cycle after busy falls, which leaves one bubble between batches.
- Output timing:
  - Registered outputs. Lane 0 appears with out_valid=1 and out_idx=0 on the cycle after the accepted capture (latency 1).
  - Each transfer presents lane idx+1 the next cycle, giving 1 element/cycle with out_ready held high.
  - While out_valid=1 and out_ready=0: out_data, out_idx and out_last hold stable and idx does not advance.
  - After the final transfer, the next cycle has out_valid=0 and out_last=0; out_data holds its last value.
- Arithmetic, per lane, in this order:
  - Arithmetic right shift by shift_amt, truncating toward negative infinity.
  - shift_amt >= acc_width yields 0 for non-negative lanes and -1 for negative lanes.
  - If relu_en, negative results become 0.
  - Saturate to [-2^(out_width-1), 2^(out_width-1)-1].
  - sat_flag sets on the cycle a clamped element is presented and stays set until the next accepted capture or reset.
- Single lane: size=1 → out_last=1 on the only element.

Test Plan:
- Reset priority: hold rst_n=0 with capture=1 for 3 cycles → all outputs 0, busy stays 0, no element emitted after release.
- Saturation pass: size=4, acc_width=32, out_width=8; lanes 0..3 = {5, 100, -3, 400}, shift_amt=0, relu_en=0, out_ready=1.
  - Required: out_data = 5, 100, -3, 127 on the 4 cycles following capture, out_idx = 0..3.
  - out_last high only on the 4th; sat_flag=1 from the 4th cycle; busy low the cycle after.
- Shift plus ReLU: lanes {256, -40, 2047, 160}, shift_amt=4, relu_en=1.
  - Required: out_data = 16, 0, 127, 10; sat_flag stays 0.
  - Repeat with relu_en=0 → second element = -3.
- Backpressure: same lanes as the saturation pass, out_ready pattern 1,0,0,1,1,0,1.
  - Required: exactly 4 transfers in order; out_data and out_idx stable on every stalled cycle; no duplicated or skipped lane.
- Capture collision:
  - capture pulsed mid-drain → ignored.
  - capture on the final-transfer cycle → ignored.
  - capture on the cycle busy=0 → accepted; new lane 0 appears the next cycle and sat_flag is cleared.
- Mid-drain reset: rst_n=0 for 1 cycle after 2 transfers → next cycle out_valid=0, busy=0. A new capture restarts at out_idx=0 with the new data.

Source files
------------

// File: rtl/mac_chain_drain.sv
// Drain stage of the MAC chain: captures all accumulator lanes at once, then streams
// shifted / ReLU'd / saturated elements one lane per cycle over valid/ready.

module mac_chain_drain_lane #(
  parameter int acc_width = 32,
  parameter int out_width = 8
) (
  input  logic [acc_width-1:0] acc,
  input  logic [5:0]           shift_amt,
  input  logic                 relu_en,
  output logic [out_width-1:0] res,
  output logic                 sat
);
  localparam logic signed [acc_width-1:0] MAXV = acc_width'(2**(out_width-1)-1);
  localparam logic signed [acc_width-1:0] MINV = ~MAXV;

  logic signed [acc_width-1:0] sh;

  always_comb begin
    // Shifts at or past the lane width collapse to the sign.
    if (32'(shift_amt) >= acc_width) sh = {acc_width{acc[acc_width-1]}};
    else                             sh = $signed(acc) >>> shift_amt;
    if (relu_en && sh[acc_width-1]) sh = '0;
    sat = 1'b0;
    res = sh[out_width-1:0];
    if (sh > MAXV) begin
      res = MAXV[out_width-1:0];
      sat = 1'b1;
    end else if (sh < MINV) begin
      res = MINV[out_width-1:0];
      sat = 1'b1;
    end
  end
endmodule

module mac_chain_drain #(
  parameter int size      = 4,
  parameter int acc_width = 32,
  parameter int out_width = 8,
  parameter int idx_width = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      capture,
  input  logic [size*acc_width-1:0] acc_in,
  input  logic [5:0]                shift_amt,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [out_width-1:0]      out_data,
  output logic [idx_width-1:0]      out_idx,
  output logic                      out_last,
  output logic                      sat_flag
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state;

  logic [size-1:0][out_width-1:0] res_c, res_q;
  logic [size-1:0]                sat_c, sat_q;
  logic [idx_width-1:0]           nxt_idx;

  // Lanes are post-processed on the way in, so the drain is just a mux.
  for (genvar i = 0; i < size; i++) begin : g_lane
    mac_chain_drain_lane #(.acc_width(acc_width), .out_width(out_width)) u_lane (
      .acc       (acc_in[i*acc_width +: acc_width]),
      .shift_amt (shift_amt),
      .relu_en   (relu_en),
      .res       (res_c[i]),
      .sat       (sat_c[i])
    );
  end

  assign nxt_idx = out_idx + idx_width'(1);
  assign busy    = (state == DRAIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
      res_q     <= '0;
      sat_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (capture) begin
            state     <= DRAIN;
            res_q     <= res_c;
            sat_q     <= sat_c;
            out_valid <= 1'b1;
            out_data  <= res_c[0];
            out_idx   <= '0;
            out_last  <= (size == 1);
            sat_flag  <= sat_c[0];
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_idx  <= nxt_idx;
              out_data <= res_q[nxt_idx];
              out_last <= (nxt_idx == idx_width'(size-1));
              sat_flag <= sat_flag | sat_q[nxt_idx];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_chain_drain.sv
// Directed bench for mac_chain_drain: queue-based reference model checked every cycle,
// plus literal expectations for the headline scenarios.

module tb_mac_chain_drain;
  localparam int SIZE = 4, AW = 32, OW = 8, IW = 2;

  logic clk = 1'b0, rst_n = 1'b0, capture = 1'b0, relu_en = 1'b0, out_ready = 1'b1;
  logic [SIZE*AW-1:0] acc_in = '0;
  logic [5:0] shift_amt = '0;
  logic busy, out_valid, out_last, sat_flag;
  logic [OW-1:0] out_data;
  logic [IW-1:0] out_idx;

  mac_chain_drain #(.size(SIZE), .acc_width(AW), .out_width(OW), .idx_width(IW)) dut (
    .clk(clk), .rst_n(rst_n), .capture(capture), .acc_in(acc_in), .shift_amt(shift_amt),
    .relu_en(relu_en), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: floor division by 2^sh, then ReLU, then clamp.
  function automatic void proc(input longint a, input int sh, input bit relu,
                               output int v, output bit s);
    longint q, d;
    if (sh >= AW) q = (a < 0) ? -1 : 0;
    else begin
      d = longint'(1) << sh;
      q = a / d;
      if (a < 0 && (a % d) != 0) q = q - 1;
    end
    if (relu && q < 0) q = 0;
    s = 1'b0;
    if (q > 127)       begin v = 127;  s = 1'b1; end
    else if (q < -128) begin v = -128; s = 1'b1; end
    else v = int'(q);
  endfunction

  typedef struct { int data; int idx; bit last; bit sat; } elem_t;
  elem_t q[$];
  int    m_data = 0;
  bit    m_sat = 1'b0, started = 1'b0;

  // Model: queue of elements still owed to the consumer, head is the one on the bus.
  always @(posedge clk) begin
    elem_t e;
    started = 1'b1;
    if (!rst_n) begin
      q.delete();
      m_data = 0;
      m_sat  = 1'b0;
    end else if (q.size() == 0) begin
      if (capture) begin
        for (int i = 0; i < SIZE; i++) begin
          proc(longint'($signed(acc_in[i*AW +: AW])), int'(shift_amt), relu_en, e.data, e.sat);
          e.idx  = i;
          e.last = (i == SIZE-1);
          q.push_back(e);
        end
        m_sat  = q[0].sat;
        m_data = q[0].data;
      end
    end else if (out_ready) begin
      void'(q.pop_front());
      if (q.size() > 0) begin
        m_sat  = m_sat | q[0].sat;
        m_data = q[0].data;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", longint'(out_valid), longint'(q.size() > 0));
      chk("m_busy",  longint'(busy),      longint'(q.size() > 0));
      chk("m_data",  longint'($signed(out_data)), longint'(m_data));
      chk("m_sat",   longint'(sat_flag),  longint'(m_sat));
      if (q.size() > 0) begin
        chk("m_idx",  longint'(out_idx),  longint'(q[0].idx));
        chk("m_last", longint'(out_last), longint'(q[0].last));
      end else chk("m_last_idle", longint'(out_last), 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int a0, input int a1, input int a2, input int a3,
                      input int sh, input bit r);
    acc_in    = {a3, a2, a1, a0};
    shift_amt = 6'(sh);
    relu_en   = r;
  endtask

  task automatic cap();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic expect_batch(input string name, input int e0, input int e1, input int e2,
                              input int e3, input bit sat_last);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      chk({name, "_data"}, longint'($signed(out_data)), longint'(e[k]));
      chk({name, "_idx"},  longint'(out_idx), k);
      chk({name, "_last"}, longint'(out_last), longint'(k == 3));
      if (k == 3) chk({name, "_sat"}, longint'(sat_flag), longint'(sat_last));
      tick();
    end
    chk({name, "_busy_after"}, longint'(busy), 0);
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int v, xfers;
    bit s;
    bit pat[7];

    // reset dominates capture
    load(5, 100, -3, 400, 0, 1'b0);
    rst_n = 1'b0; capture = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_busy", longint'(busy), 0);
      chk("rst_valid", longint'(out_valid), 0);
      chk("rst_data", longint'(out_data), 0);
      chk("rst_idx", longint'(out_idx), 0);
      chk("rst_sat", longint'(sat_flag), 0);
    end
    capture = 1'b0; rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_valid", longint'(out_valid), 0);

    // pin the reference arithmetic
    proc(400, 0, 1'b0, v, s);    chk("model_clamp_hi", v, 127); chk("model_clamp_flag", s, 1);
    proc(-40, 4, 1'b0, v, s);    chk("model_floor", v, -3);
    proc(-40, 4, 1'b1, v, s);    chk("model_relu", v, 0);
    proc(-5, 40, 1'b0, v, s);    chk("model_bigshift", v, -1);
    proc(-1000, 0, 1'b0, v, s);  chk("model_clamp_lo", v, -128);

    // saturation pass
    load(5, 100, -3, 400, 0, 1'b0); cap();
    expect_batch("satpass", 5, 100, -3, 127, 1'b1);

    // shift + relu, then shift without relu
    load(256, -40, 2047, 160, 4, 1'b1); cap();
    expect_batch("relu", 16, 0, 127, 10, 1'b0);
    load(256, -40, 2047, 160, 4, 1'b0); cap();
    expect_batch("norelu", 16, -3, 127, 10, 1'b0);

    // negative clamp and shift beyond lane width
    load(-1000, 7, -1, 300, 0, 1'b0); cap();
    expect_batch("negclamp", -128, 7, -1, 127, 1'b1);
    load(-5, 7, -1, 1000, 40, 1'b0); cap();
    expect_batch("bigshift", -1, 0, -1, 0, 1'b0);

    // backpressure
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    xfers = 0;
    load(5, 100, -3, 400, 0, 1'b0); cap();
    for (int c = 0; c < 7; c++) begin
      out_ready = pat[c];
      chk("bp_idx", longint'(out_idx), xfers);
      if (out_valid && out_ready) xfers++;
      tick();
    end
    out_ready = 1'b1;
    chk("bp_xfers", xfers, 4);
    chk("bp_busy", longint'(busy), 0);

    // capture collisions
    load(5, 100, -3, 400, 0, 1'b0); cap();
    tick();
    load(256, -40, 2047, 160, 4, 1'b1); cap();   // mid-drain, ignored
    chk("coll_mid_idx", longint'(out_idx), 2);
    tick();
    chk("coll_last", longint'(out_last), 1);
    load(1, 2, 3, 4, 0, 1'b0); cap();            // on final transfer, ignored
    chk("coll_final_busy", longint'(busy), 0);
    chk("coll_final_valid", longint'(out_valid), 0);
    chk("coll_final_data_hold", longint'($signed(out_data)), 127);
    load(256, -40, 2047, 160, 4, 1'b1); cap();   // busy=0, accepted
    chk("coll_new_data", longint'($signed(out_data)), 16);
    chk("coll_new_idx", longint'(out_idx), 0);
    chk("coll_new_sat", longint'(sat_flag), 0);
    drain();
    tick();

    // reset mid-drain
    load(5, 100, -3, 400, 0, 1'b0); cap();
    tick(); tick();
    chk("mid_rst_pre_idx", longint'(out_idx), 2);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    tick();
    chk("mid_rst_stay_idle", longint'(out_valid), 0);
    load(-1000, 7, -1, 300, 0, 1'b0); cap();
    chk("restart_idx", longint'(out_idx), 0);
    chk("restart_data", longint'($signed(out_data)), -128);
    chk("restart_sat", longint'(sat_flag), 1);
    drain();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
